mul_seq: RTL
============

Name: mul_seq

Overview:
- Iterative RV32M multiply sequencer (MUL, MULH, MULHSU, MULHU).
- Time-shares one external 32-bit ripple adder instance (carry-in, X, Y, S, carry-out) for:
  - operand sign fix-up,
  - shift-and-add accumulation,
  - product negation.
- Sits beside the ALU in the execute stage. The core stalls while busy and captures the result on done.

Parameters:
- N, 32, operand/adder width. Latency scales with N.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request; accepted only in IDLE
- funct  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- rs1  input  N  multiplicand, sampled on accept
- rs2  input  N  multiplier, sampled on accept
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  N  product word; held until next accept or reset
- add_cin  output  1  to adder carry-in
- add_x  output  N  to adder X
- add_y  output  N  to adder Y
- add_s  input  N  adder sum
- add_cout  input  1  adder carry-out

Behaviour:
- Reset (synchronous): state=IDLE, busy=0, done=0, result=0. Internal regs a, hi, lo, cnt, neg_a, neg_b, fsel and cy are cleared.
- Reset mid-operation aborts immediately. No done pulse follows.
- Adder control in IDLE and DONE: add_x, add_y and add_cin are driven 0.
- Accept: start=1 while IDLE at edge E.
  - Latch a=rs1, lo=rs2, hi=0, fsel=funct.
  - neg_a = rs1[N-1] & (funct==01 | funct==10).
  - neg_b = rs2[N-1] & (funct==01).
  - Next state PREP_A. busy=1 from the cycle after E.
- start is ignored while busy, including the DONE cycle. rs1, rs2 and funct changes after accept are ignored.
- PREP_A (1 cycle): add_x=a^{N{neg_a}}, add_y=0, add_cin=neg_a. Latch a<=add_s. This gives |rs1| or rs1.
- PREP_B (1 cycle): same with lo and neg_b. Latch lo<=add_s. cnt<=0.
- MULT (N cycles):
  - add_x=hi, add_y=lo[0]?a:0, add_cin=0.
  - {hi,lo} <= {add_cout, add_s, lo[N-1:1]}. This is a right shift of the 2N+1 value {cout,sum,lo}.
  - cnt increments. Exit after cnt reaches N-1.
- Signed product, |rs1|=2^(N-1): treated as unsigned 2^(N-1). The result is still correct mod 2^2N.
- neg_p = neg_a ^ neg_b.
- FIX_LO (1 cycle): add_x=lo^{N{neg_p}}, add_y=0, add_cin=neg_p. Latch lo<=add_s, cy<=add_cout.
- FIX_HI (1 cycle): add_x=hi^{N{neg_p}}, add_y=0, add_cin=neg_p&cy. Latch hi<=add_s.
- DONE (1 cycle):
  - done=1, busy=1.
  - result <= (fsel==00) ? lo : hi. result is registered at entry to DONE, so it is visible in the done cycle.
  - Next state IDLE.
- Latency: the done cycle is the (N+5)th cycle after the accept edge. With N=32 that is 37 cycles. Next accept is possible the cycle after done.
- funct 00 (MUL): no negation. Low word is sign-independent.
- Adder is combinational and external. The controller assumes add_s/add_cout are valid in the same cycle as the drive.

Test Plan:
- MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> result=0xFFFFFFFE. done exactly 37 cycles after accept. busy high 37 cycles.
- MUL with the same operands -> 0x00000001. MUL 0x00000000 x 0x12345678 -> 0x00000000.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0x00000007 x 0xFFFFFFFD -> 0xFFFFFFFF. MUL same -> 0xFFFFFFEB.
- MULHSU rs1=0xFFFFFFFF (-1) rs2=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF. MULHSU 0x00000002 x 0x80000000 -> 0x00000001.
- Hold start=1 and change rs1/rs2 every cycle during the operation -> one done pulse only, with the result of the first operands. Re-accept occurs the cycle after done.
- Assert reset at cycle 10 of MULT -> next cycle busy=0, done=0, result=0, no done pulse. A new MULHU 3x5 afterwards -> 0x00000000. MUL 3x5 -> 0x0000000F.

Source files
------------

// File: rtl/mul_seq.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) built around one shared
// external ripple adder used for sign fix-up, shift-and-add and negation.
module mul_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   funct,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         add_cin,
  output logic [N-1:0] add_x,
  output logic [N-1:0] add_y,
  input  logic [N-1:0] add_s,
  input  logic         add_cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP_A,
    S_PREP_B,
    S_MULT,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    a, hi, lo;
  logic [CW-1:0]   cnt;
  logic            neg_a, neg_b, cy;
  logic [1:0]      fsel;
  logic            neg_p;

  assign neg_p = neg_a ^ neg_b;
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and adder operand steering; the adder idles at zero outside
  // the states that actually use it.
  always_comb begin
    state_nxt = state;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_PREP_A;
      end
      S_PREP_A: begin
        add_x     = a ^ {N{neg_a}};
        add_cin   = neg_a;
        state_nxt = S_PREP_B;
      end
      S_PREP_B: begin
        add_x     = lo ^ {N{neg_b}};
        add_cin   = neg_b;
        state_nxt = S_MULT;
      end
      S_MULT: begin
        add_x = hi;
        add_y = lo[0] ? a : '0;
        if (cnt == CW'(N - 1)) state_nxt = S_FIX_LO;
      end
      S_FIX_LO: begin
        add_x     = lo ^ {N{neg_p}};
        add_cin   = neg_p;
        state_nxt = S_FIX_HI;
      end
      S_FIX_HI: begin
        add_x     = hi ^ {N{neg_p}};
        add_cin   = neg_p & cy;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a      <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      fsel   <= '0;
      cy     <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a     <= rs1;
            lo    <= rs2;
            hi    <= '0;
            fsel  <= funct;
            neg_a <= rs1[N-1] & ((funct == 2'b01) | (funct == 2'b10));
            neg_b <= rs2[N-1] & (funct == 2'b01);
          end
        end
        S_PREP_A: a <= add_s;
        S_PREP_B: begin
          lo  <= add_s;
          cnt <= '0;
        end
        // {cout,sum,lo} shifted right by one into {hi,lo}
        S_MULT: begin
          hi  <= {add_cout, add_s[N-1:1]};
          lo  <= {add_s[0], lo[N-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_FIX_LO: begin
          lo <= add_s;
          cy <= add_cout;
        end
        // result is taken from the freshly negated high word so it is
        // already visible in the done cycle
        S_FIX_HI: begin
          hi     <= add_s;
          result <= (fsel == 2'b00) ? lo : add_s;
        end
        default: ;
      endcase
    end
  end

endmodule
